msg_pad_feeder: RTL and testbench

Host-side message feeder for the cSHAKE core. It accepts a byte-oriented message stream, applies cSHAKE multi-rate padding, and splits the result into rate blocks. It then drives the `PARALLEL_SLICES`-wide `din` word stream that the absorb path writes into state RAM, stalling at every block boundary until the permutation of that block completes.

---
 rtl/msg_pad_feeder_pkg.sv | 38 +++
 rtl/msg_pad_feeder_skid.sv | 72 +++++++
 rtl/msg_pad_feeder.sv | 235 +++++++++++++++++++++++
 tb/tb_msg_pad_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pad_feeder_pkg.sv
// Shared constants, state encoding and byte helpers for the cSHAKE message
// pad feeder.
package msg_pad_feeder_pkg;

  localparam int RATE_128  = 1344;
  localparam int RATE_256  = 1088;
  localparam int WORDS_128 = 84;
  localparam int WORDS_256 = 68;

  localparam logic [7:0] PAD_DOMAIN = 8'h04;
  localparam logic [7:0] PAD_LAST   = 8'h80;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MSG       = 3'd1,
    PAD       = 3'd2,
    ZERO      = 3'd3,
    WAIT_PERM = 3'd4,
    WAIT_LAST = 3'd5
  } feeder_state_e;

  // Closing bit of the multi-rate pad, merged into whatever the byte holds.
  function automatic logic [7:0] mark_last(input logic [7:0] b);
    return b | PAD_LAST;
  endfunction

  // Block length in words for the selected rate.
  function automatic logic [6:0] block_words(input logic sel256, input int win);
    logic [6:0] w;
    if (sel256) begin
      w = 7'(RATE_256 / win);
    end else begin
      w = 7'(RATE_128 / win);
    end
    return w;
  endfunction

endpackage

// File: rtl/msg_pad_feeder_skid.sv
// Two-entry skid buffer for the host side of the pad feeder: registered
// ready towards the host, so no combinational path back from the absorb side.
module feeder_skid
  import msg_pad_feeder_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         en,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic [1:0]   cnt_next_s;
  logic         in_ready_r;
  logic         push_s;
  logic         pop_s;

  assign push_s    = in_valid && in_ready_r;
  assign pop_s     = (cnt_r != 2'd0) && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = (cnt_r != 2'd0);
  assign out_data  = mem_r[rd_ptr_r];

  // Occupancy after this cycle's push and pop.
  always_comb begin
    cnt_next_s = cnt_r;
    if (push_s && !pop_s) begin
      cnt_next_s = cnt_r + 2'd1;
    end else if (pop_s && !push_s) begin
      cnt_next_s = cnt_r - 2'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Pointers, count and the registered host ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      cnt_r      <= 2'd0;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r      <= cnt_next_s;
      in_ready_r <= en && (cnt_next_s < 2'd2);
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

endmodule

// File: rtl/msg_pad_feeder.sv
// cSHAKE host message feeder: pads a byte stream and splits it into rate
// blocks of WIN-bit words. Define FEEDER_SKID_EN to buffer the host input.
module msg_pad_feeder
  import msg_pad_feeder_pkg::*;
#(
  parameter int WIN      = 16,
  parameter int RATE_128 = msg_pad_feeder_pkg::RATE_128,
  parameter int RATE_256 = msg_pad_feeder_pkg::RATE_256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mux256,
  input  logic [WIN-1:0]          msg_data,
  input  logic                    msg_valid,
  input  logic                    msg_last,
  input  logic [$clog2(WIN/8):0]  msg_bytes,
  output logic                    msg_ready,
  output logic [WIN-1:0]          din,
  output logic                    din_valid,
  input  logic                    din_ready,
  output logic                    bof,
  output logic                    block_done,
  input  logic                    perm_done,
  output logic                    done
);

  localparam int NB = WIN / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam logic [BW-1:0] NB_FULL = BW'(NB);
  localparam logic [6:0] WORDS_A = 7'(RATE_128 / WIN);
  localparam logic [6:0] WORDS_B = 7'(RATE_256 / WIN);

  feeder_state_e  state_r;
  logic [6:0]     wcnt_r;
  logic [6:0]     words_r;
  logic           first_r;
  logic           pend_pad_r;
  logic           din_end_r;
  logic [WIN-1:0] din_r;
  logic           din_valid_r;
  logic           bof_r;
  logic           block_done_r;
  logic           done_r;

  logic           in_valid_s;
  logic           in_ready_s;
  logic           in_last_s;
  logic [WIN-1:0] in_data_s;
  logic [BW-1:0]  in_bytes_s;

  logic           can_emit_s;
  logic           at_end_s;
  logic           full_s;
  logic           load_s;
  logic [WIN-1:0] word_s;

  // Bytes at and above the valid count of a final word carry the domain byte
  // then zeros; mark adds the closing pad bit to the top byte.
  function automatic logic [WIN-1:0] fmt_word(input logic [WIN-1:0] data,
                                              input logic            last,
                                              input logic [BW-1:0]   nb,
                                              input logic            mark);
    logic [WIN-1:0] w;
    w = data;
    for (int k = 0; k < NB; k++) begin
      if (last && (k == int'(nb))) begin
        w[8*k +: 8] = PAD_DOMAIN;
      end else if (last && (k > int'(nb))) begin
        w[8*k +: 8] = 8'h00;
      end else begin
        w[8*k +: 8] = data[8*k +: 8];
      end
    end
    if (mark) begin
      w[WIN-1 -: 8] = mark_last(w[WIN-1 -: 8]);
    end
    return w;
  endfunction

`ifdef FEEDER_SKID_EN
  logic [WIN+BW:0] skid_out_s;
  logic            skid_en_s;

  assign skid_en_s  = (state_r == MSG);
  assign in_data_s  = skid_out_s[WIN-1:0];
  assign in_bytes_s = skid_out_s[WIN+BW-1:WIN];
  assign in_last_s  = skid_out_s[WIN+BW];

  feeder_skid #(
    .W (WIN + BW + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({msg_last, msg_bytes, msg_data}),
    .in_valid  (msg_valid),
    .in_ready  (msg_ready),
    .en        (skid_en_s),
    .out_data  (skid_out_s),
    .out_valid (in_valid_s),
    .out_ready (in_ready_s)
  );
`else
  assign in_valid_s = msg_valid;
  assign in_data_s  = msg_data;
  assign in_last_s  = msg_last;
  assign in_bytes_s = msg_bytes;
  assign msg_ready  = in_ready_s;
`endif

  assign din        = din_r;
  assign din_valid  = din_valid_r;
  assign bof        = bof_r;
  assign block_done = block_done_r;
  assign done       = done_r;

  // Output slot availability and the word to load this cycle.
  always_comb begin
    can_emit_s = !din_valid_r || din_ready;
    at_end_s   = (wcnt_r == (words_r - 7'd1));
    full_s     = (in_bytes_s == NB_FULL);
    in_ready_s = (state_r == MSG) && can_emit_s;
    load_s     = 1'b0;
    word_s     = '0;
    case (state_r)
      MSG: begin
        load_s = in_valid_s && in_ready_s;
        // A full final word in the last slot defers the pad to an extra block.
        word_s = fmt_word(in_data_s, in_last_s, in_bytes_s,
                          in_last_s && !full_s && at_end_s);
      end
      PAD: begin
        load_s = can_emit_s;
        word_s = fmt_word('0, 1'b1, '0, at_end_s);
      end
      ZERO: begin
        load_s = can_emit_s;
        word_s = fmt_word('0, 1'b0, '0, at_end_s);
      end
      default: begin
        load_s = 1'b0;
        word_s = '0;
      end
    endcase
  end

  // Feeder state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wcnt_r       <= 7'd0;
      words_r      <= WORDS_A;
      first_r      <= 1'b0;
      pend_pad_r   <= 1'b0;
      din_end_r    <= 1'b0;
      din_r        <= '0;
      din_valid_r  <= 1'b0;
      bof_r        <= 1'b0;
      block_done_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      block_done_r <= 1'b0;
      done_r       <= 1'b0;

      if (din_valid_r && din_ready) begin
        din_valid_r  <= 1'b0;
        bof_r        <= 1'b0;
        block_done_r <= din_end_r;
      end

      if (load_s) begin
        din_r       <= word_s;
        din_valid_r <= 1'b1;
        bof_r       <= first_r && (wcnt_r == 7'd0);
        din_end_r   <= at_end_s;
        first_r     <= 1'b0;
        wcnt_r      <= at_end_s ? 7'd0 : (wcnt_r + 7'd1);
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            words_r    <= mux256 ? WORDS_B : WORDS_A;
            wcnt_r     <= 7'd0;
            first_r    <= 1'b1;
            pend_pad_r <= 1'b0;
            state_r    <= MSG;
          end
        end
        MSG: begin
          if (load_s && in_last_s) begin
            if (full_s && at_end_s) begin
              pend_pad_r <= 1'b1;
              state_r    <= WAIT_PERM;
            end else if (at_end_s) begin
              state_r <= WAIT_LAST;
            end else if (full_s) begin
              state_r <= PAD;
            end else begin
              state_r <= ZERO;
            end
          end else if (load_s && at_end_s) begin
            state_r <= WAIT_PERM;
          end
        end
        PAD: begin
          if (load_s) begin
            state_r <= at_end_s ? WAIT_LAST : ZERO;
          end
        end
        ZERO: begin
          if (load_s && at_end_s) begin
            state_r <= WAIT_LAST;
          end
        end
        WAIT_PERM: begin
          if (perm_done) begin
            state_r    <= pend_pad_r ? PAD : MSG;
            pend_pad_r <= 1'b0;
          end
        end
        WAIT_LAST: begin
          if (perm_done) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_pad_feeder.sv
// Scoreboard bench for msg_pad_feeder: a byte-level pad model fills the
// expected queue, a monitor checks every din transfer and the pulse outputs.
module tb_msg_pad_feeder;

  localparam int RB128 = 1344 / 8;
  localparam int RB256 = 1088 / 8;
`ifdef FEEDER_SKID_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] w;
    bit          bof;
    bit          blk_end;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mux256;
  logic [15:0] msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic [1:0]  msg_bytes;
  logic        msg_ready;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        bof;
  logic        block_done;
  logic        perm_done;
  logic        done;

  logic        perm_resp;
  logic        perm_spur;
  logic        perm_final;

  exp_t        exp_q[$];
  logic [7:0]  msg_mem[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc0 = -100;
  int          blocks_left = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  int          force_low = 0;

  assign perm_done = perm_resp | perm_spur;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  msg_pad_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux256     (mux256),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_bytes  (msg_bytes),
    .msg_ready  (msg_ready),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .bof        (bof),
    .block_done (block_done),
    .perm_done  (perm_done),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Absorb-side ready: forced low windows, random, or always ready.
  initial begin
    din_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_low > 0) begin
        din_ready = 1'b0;
        force_low--;
      end else if (ready_mode == 1) begin
        din_ready = ($urandom_range(0, 9) < 7);
      end else begin
        din_ready = 1'b1;
      end
    end
  end

  // Permutation stand-in: answers each block_done after a random delay.
  initial begin
    bit fin;
    perm_resp  = 1'b0;
    perm_final = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && block_done) begin
        fin = (blocks_left == 1);
        blocks_left--;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(posedge clk);
        #1;
        perm_resp  = 1'b1;
        perm_final = fin;
        @(posedge clk);
        #1;
        perm_resp  = 1'b0;
        perm_final = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on din transfers plus pulse and hold checks.
  initial begin
    exp_t        e;
    bit          prev_stall = 1'b0;
    bit          exp_bd = 1'b0;
    bit          exp_done = 1'b0;
    bit          prev_bof = 1'b0;
    logic [15:0] prev_din = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        exp_bd     = 1'b0;
        exp_done   = 1'b0;
        prev_bof   = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("din_hold", 32'(din), 32'(prev_din));
          chk("valid_hold", 32'(din_valid), 32'd1);
        end
`ifndef FEEDER_SKID_EN
        if (din_valid && !din_ready) chk("msg_ready_in_stall", 32'(msg_ready), 32'd0);
`endif
        chk("block_done", 32'(block_done), 32'(exp_bd));
        chk("done", 32'(done), 32'(exp_done));
        if (done) done_cnt++;
        if (bof && !prev_bof) chk("host_to_din_latency", 32'(cyc - acc_cyc0), 32'(LAT));
        exp_bd = 1'b0;
        if (din_valid && din_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("din", 32'(din), 32'(e.w));
            chk("bof", 32'(bof), 32'(e.bof));
            exp_bd = e.blk_end;
          end
        end
        exp_done   = perm_done && perm_final;
        prev_stall = din_valid && !din_ready;
        prev_din   = din;
        prev_bof   = bof;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_din_valid"}, 32'(din_valid), 32'd0);
    chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
    chk({tag, "_bof"}, 32'(bof), 32'd0);
    chk({tag, "_block_done"}, 32'(block_done), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Sends msg_mem as one message; entered and left just after a posedge.
  task automatic send_msg(input bit m256, input int abort_at, input bit stall_first);
    logic [7:0] p[$];
    exp_t       e;
    int         n;
    int         rb;
    int         nw;
    int         guard;
    int         target;
    logic [7:0] b0;
    logic [7:0] b1;
    n  = msg_mem.size();
    rb = m256 ? RB256 : RB128;
    // Reference: append domain byte, zero-fill to a whole block, close with 0x80.
    p = msg_mem;
    p.push_back(8'h04);
    while ((p.size() % rb) != 0) p.push_back(8'h00);
    p[p.size() - 1] = p[p.size() - 1] | 8'h80;
    for (int i = 0; i < p.size() / 2; i++) begin
      e.w       = {p[2*i + 1], p[2*i]};
      e.bof     = (i == 0);
      e.blk_end = (((2*i + 2) % rb) == 0);
      exp_q.push_back(e);
    end
    blocks_left = p.size() / rb;
    target      = done_cnt + 1;

    start  = 1'b1;
    mux256 = m256;
    @(posedge clk);
    #1;
    start = 1'b0;

    nw = (n == 0) ? 1 : (n + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      if (w == abort_at) begin
        rst       = 1'b1;
        msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("abort");
        exp_q.delete();
        blocks_left = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      b0 = (2*w < n)     ? msg_mem[2*w]     : 8'($urandom);
      b1 = (2*w + 1 < n) ? msg_mem[2*w + 1] : 8'($urandom);
      msg_data  = {b1, b0};
      msg_last  = (w == nw - 1);
      msg_bytes = msg_last ? 2'(n - 2*w) : 2'($urandom_range(0, 2));
      msg_valid = 1'b1;
      if (w == 3 && nw > 8) begin
        start     = 1'b1;
        perm_spur = 1'b1;
      end
      guard = 0;
      @(negedge clk);
      while (!msg_ready && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (!msg_ready) begin
        chk("host_accept_timeout", 32'(msg_ready), 32'd1);
        msg_valid = 1'b0;
        start     = 1'b0;
        perm_spur = 1'b0;
        exp_q.delete();
        return;
      end
      if (w == 0) acc_cyc0 = cyc;
      @(posedge clk);
      #1;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      start     = 1'b0;
      perm_spur = 1'b0;
      if (w == 0 && stall_first) force_low = 5;
    end

    guard = 0;
    while (done_cnt < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 32'(done_cnt), 32'(target));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    mux256    = 1'b0;
    msg_data  = 16'h0000;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_bytes = 2'd0;
    perm_spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc" at the 128 rate.
    msg_mem = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, -1, 1'b0);

    // Empty message.
    msg_mem.delete();
    send_msg(1'b0, -1, 1'b0);

    // 167 bytes: domain byte and closing bit share the top byte.
    msg_mem.delete();
    for (int i = 0; i < 166; i++) msg_mem.push_back(8'($urandom));
    msg_mem.push_back(8'hAA);
    send_msg(1'b0, -1, 1'b0);

    // 168 bytes: exactly one full block, pad spills into a second block.
    msg_mem.delete();
    for (int i = 0; i < 168; i++) msg_mem.push_back(8'($urandom));
    send_msg(1'b0, -1, 1'b0);

    // "abc" at the 256 rate with a five-cycle absorb stall on word 0.
    msg_mem = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b1, -1, 1'b1);

    // Reset in the middle of a message, then a clean restart.
    msg_mem.delete();
    for (int i = 0; i < 200; i++) msg_mem.push_back(8'($urandom));
    send_msg(1'b0, 40, 1'b0);
    msg_mem = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0, -1, 1'b0);

    // Random lengths, rates and absorb backpressure.
    ready_mode = 1;
    for (int m = 0; m < 8; m++) begin
      msg_mem.delete();
      n = $urandom_range(0, 400);
      for (int i = 0; i < n; i++) msg_mem.push_back(8'($urandom));
      send_msg(1'($urandom_range(0, 1)), -1, 1'b0);
    end
    ready_mode = 0;

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
